// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: gathers WIDTH bits MSB- or LSB-first into a one-entry
// valid/ready output buffer, with a sticky overrun flag for words lost to back-pressure.
module shift_deserializer #(
  parameter int WIDTH      = 4,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] p,
  output logic             p_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_sr, w_sr_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic               r_dir, w_dir_nxt;
  logic [WIDTH-1:0]   r_p, w_p_nxt;
  logic               r_p_valid, w_p_valid_nxt;
  logic               r_overrun, w_overrun_nxt;

  logic [WIDTH-1:0]   w_sr_shifted;
  logic               w_complete;
  logic               w_consume;

  assign w_sr_shifted = r_dir ? {sin, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], sin};
  // A completing bit is taken even when start arrives with it; the new frame follows.
  assign w_complete   = (r_state == S_SHIFT) && sin_valid &&
                        (r_count == CNT_W'(WIDTH - 1));
  assign w_consume    = r_p_valid && out_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_count_nxt   = r_count;
    w_dir_nxt     = r_dir;
    w_p_nxt       = r_p;
    w_p_valid_nxt = r_p_valid;
    w_overrun_nxt = r_overrun;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SHIFT;
          w_dir_nxt   = dir;
          w_count_nxt = '0;
          w_sr_nxt    = '0;
        end
      end
      S_SHIFT: begin
        if (w_complete) begin
          w_sr_nxt    = '0;
          w_count_nxt = '0;
          w_state_nxt = CONTINUOUS ? S_SHIFT : S_IDLE;
        end else if (sin_valid && !start) begin
          w_sr_nxt    = w_sr_shifted;
          w_count_nxt = r_count + CNT_W'(1);
        end
        if (start) begin
          w_state_nxt = S_SHIFT;
          w_dir_nxt   = dir;
          w_count_nxt = '0;
          w_sr_nxt    = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_complete) begin
      if (!r_p_valid || out_ready) begin
        w_p_nxt       = w_sr_shifted;
        w_p_valid_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end else if (w_consume) begin
      w_p_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sr      <= '0;
      r_count   <= '0;
      r_dir     <= 1'b0;
      r_p       <= '0;
      r_p_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_count   <= w_count_nxt;
      r_dir     <= w_dir_nxt;
      r_p       <= w_p_nxt;
      r_p_valid <= w_p_valid_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign p       = r_p;
  assign p_valid = r_p_valid;
  assign overrun = r_overrun;
  assign busy    = (r_state == S_SHIFT);

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: single-shot (dut0) and continuous (dut1) instances
// share stimulus; expected words flow through a scoreboard queue.
module tb_shift_deserializer;

  logic       clk = 1'b0;
  logic       rst, start, dir, sin, sin_valid, out_ready;
  logic [3:0] p0, p1;
  logic       pv0, pv1, busy0, busy1, ovr0, ovr1;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(4), .CONTINUOUS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .sin(sin), .sin_valid(sin_valid),
    .p(p0), .p_valid(pv0), .out_ready(out_ready), .busy(busy0), .overrun(ovr0));

  shift_deserializer #(.WIDTH(4), .CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .sin(sin), .sin_valid(sin_valid),
    .p(p1), .p_valid(pv1), .out_ready(out_ready), .busy(busy1), .overrun(ovr1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start(input logic d);
    start = 1'b1;
    dir   = d;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [3:0] obs, input logic obs_valid);
    logic [3:0] e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    chk({tag, "_p_valid"}, 32'(obs_valid), 32'd1);
    chk({tag, "_p"}, 32'(obs), 32'(e));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] bits8;
    rst = 1'b0; start = 1'b0; dir = 1'b0; sin = 1'b0; sin_valid = 1'b0; out_ready = 1'b0;

    // reset state
    do_reset();
    chk("rst_p", 32'(p0), 32'h0);
    chk("rst_p_valid", 32'(pv0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_overrun", 32'(ovr0), 32'h0);

    // test 1: MSB first, back-to-back
    do_start(1'b0);
    chk("t1_busy_shift", 32'(busy0), 32'h1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t1_no_early_valid", 32'(pv0), 32'h0);
    exp_q.push_back(4'b1011);
    send_bit(1'b1);
    pop_check("t1", p0, pv0);
    chk("t1_busy_idle", 32'(busy0), 32'h0);
    consume();
    chk("t1_consumed_valid", 32'(pv0), 32'h0);
    chk("t1_p_kept", 32'(p0), 32'hB);

    // test 2: LSB first with 2-cycle gaps
    do_start(1'b1);
    send_bit(1'b1); tick(); tick();
    send_bit(1'b0); tick(); tick();
    send_bit(1'b1); tick(); tick();
    chk("t2_no_early_valid", 32'(pv0), 32'h0);
    chk("t2_busy_gap", 32'(busy0), 32'h1);
    exp_q.push_back(4'b1101);
    send_bit(1'b1);
    pop_check("t2", p0, pv0);
    consume();

    // test 3a: back-pressure drops second word
    do_start(1'b0);
    exp_q.push_back(4'b1011);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    pop_check("t3a_first", p0, pv0);
    do_start(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("t3a_p_unchanged", 32'(p0), 32'hB);
    chk("t3a_p_valid", 32'(pv0), 32'h1);
    chk("t3a_overrun", 32'(ovr0), 32'h1);

    // test 3b: consume on the completion cycle replaces the word
    do_reset();
    do_start(1'b0);
    exp_q.push_back(4'b1011);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    pop_check("t3b_first", p0, pv0);
    do_start(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    out_ready = 1'b1;
    exp_q.push_back(4'b0110);
    send_bit(1'b0);
    out_ready = 1'b0;
    pop_check("t3b_replace", p0, pv0);
    chk("t3b_overrun", 32'(ovr0), 32'h0);

    // test 4: continuous mode on dut1, 8 back-to-back bits
    do_reset();
    out_ready = 1'b1;
    do_start(1'b0);
    bits8 = 8'b1100_1010;
    for (int i = 7; i >= 0; i--) begin
      if (i == 4 || i == 0)
        exp_q.push_back((i == 4) ? 4'b1100 : 4'b1010);
      send_bit(bits8[i]);
      chk("t4_busy", 32'(busy1), 32'h1);
      if (i == 4) begin
        pop_check("t4_word0", p1, pv1);
        chk("t4_dut0_idle", 32'(busy0), 32'h0);
      end
      if (i == 0) pop_check("t4_word1", p1, pv1);
    end
    out_ready = 1'b0;

    // test 5: start mid-frame aborts; the start-cycle bit is not sampled
    do_reset();
    do_start(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    start = 1'b1; dir = 1'b0; sin = 1'b1; sin_valid = 1'b1;
    tick();
    start = 1'b0; sin_valid = 1'b0;
    chk("t5_busy", 32'(busy0), 32'h1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("t5_no_early_valid", 32'(pv0), 32'h0);
    exp_q.push_back(4'b0111);
    send_bit(1'b1);
    pop_check("t5", p0, pv0);

    // start together with the completing bit: word lands, new LSB-first frame begins
    out_ready = 1'b1;
    do_start(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    exp_q.push_back(4'b1001);
    start = 1'b1; dir = 1'b1;
    send_bit(1'b1);
    start = 1'b0;
    pop_check("t5_start_complete", p0, pv0);
    chk("t5_start_complete_busy", 32'(busy0), 32'h1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    exp_q.push_back(4'b0001);
    send_bit(1'b0);
    pop_check("t5_relatched_dir", p0, pv0);
    out_ready = 1'b0;

    // test 6: async reset mid-frame clears everything before the next edge
    do_start(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("t6_setup_ovr", 32'(ovr0), 32'h1);
    do_start(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1;
    #1;
    chk("t6_async_p", 32'(p0), 32'h0);
    chk("t6_async_p_valid", 32'(pv0), 32'h0);
    chk("t6_async_busy", 32'(busy0), 32'h0);
    chk("t6_async_overrun", 32'(ovr0), 32'h0);
    #2;
    rst = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    chk("t6_idle_ignores_sin", 32'(busy0), 32'h0);
    chk("t6_idle_no_word", 32'(pv0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
